// File: rtl/box_plotter_if.sv
// Box plotter bus: upstream position/colour in, VGA pixel stream and status out.
interface box_plotter_if;
  logic       frame_tick;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  // Upstream / environment side: issues ticks and positions, observes pixels.
  modport master (
    output frame_tick, x_in, y_in, colour_in,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  // Plotter side.
  modport slave (
    input  frame_tick, x_in, y_in, colour_in,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/box_plotter.sv
// Box plotter: on each frame tick erases the box at its previous position, then
// redraws it at the new origin/colour, one pixel per clock to the VGA adapter.
// Outputs are registered from next-state values, so the first pixel of a scan is
// visible in the cycle right after the edge that enters the scan state.
module box_plotter #(
  parameter int unsigned BOX_W     = 4,
  parameter int unsigned BOX_H     = 4,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic         clock,
  input  logic         reset,
  box_plotter_if.slave bus
);

  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [7:0]    r_old_x;
  logic [6:0]    r_old_y;
  logic [2:0]    r_old_c;
  logic          r_have_prev;

  logic [7:0]    r_x_out;
  logic [6:0]    r_y_out;
  logic [2:0]    r_colour_out;
  logic          r_plot;
  logic          r_busy;
  logic          r_done;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_col_nxt;
  logic [CW-1:0] w_row_nxt;
  logic [7:0]    w_org_x;
  logic [6:0]    w_org_y;
  logic [2:0]    w_draw_c;
  logic [8:0]    w_px;
  logic [7:0]    w_py;
  logic          w_scan;
  logic          w_vis;

  // Next-state and scan-counter logic; counters only move inside ERASE/DRAW.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_tick) begin
          w_state_nxt = r_have_prev ? S_ERASE : S_LOAD;
        end
      end
      S_ERASE, S_DRAW: begin
        if (r_col == CW'(BOX_W - 1)) begin
          w_col_nxt = '0;
          if (r_row == CW'(BOX_H - 1)) begin
            w_row_nxt   = '0;
            w_state_nxt = (r_state == S_ERASE) ? S_LOAD : S_DONE;
          end else begin
            w_row_nxt = r_row + CW'(1);
          end
        end else begin
          w_col_nxt = r_col + CW'(1);
        end
      end
      S_LOAD:  w_state_nxt = S_DRAW;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel for the next cycle; LOAD forwards the incoming origin since it is captured at the same edge.
  always_comb begin
    w_org_x  = (r_state == S_LOAD) ? bus.x_in      : r_old_x;
    w_org_y  = (r_state == S_LOAD) ? bus.y_in      : r_old_y;
    w_draw_c = (r_state == S_LOAD) ? bus.colour_in : r_old_c;
    w_px     = 9'(w_org_x) + 9'(w_col_nxt);
    w_py     = 8'(w_org_y) + 8'(w_row_nxt);
    w_scan   = (w_state_nxt == S_ERASE) || (w_state_nxt == S_DRAW);
    w_vis    = (w_px < 9'(SCR_W)) && (w_py < 8'(SCR_H));
  end

  // State and scan counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Capture the new box position and colour in LOAD; it becomes the erase target next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_old_x     <= '0;
      r_old_y     <= '0;
      r_old_c     <= '0;
      r_have_prev <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_old_x     <= bus.x_in;
      r_old_y     <= bus.y_in;
      r_old_c     <= bus.colour_in;
      r_have_prev <= 1'b1;
    end
  end

  // Registered VGA pixel and status outputs; off-screen slots keep timing but suppress plot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_colour_out <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      r_plot <= w_scan && w_vis;
      if (w_scan) begin
        r_x_out      <= w_px[7:0];
        r_y_out      <= w_py[6:0];
        r_colour_out <= (w_state_nxt == S_ERASE) ? BG_COLOUR : w_draw_c;
      end else begin
        r_x_out      <= '0;
        r_y_out      <= '0;
        r_colour_out <= '0;
      end
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour_out;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
